adc_fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the card's single 16-bit synchronous sample FIFO (depth 15, write-enable/full interface) between up to four ADC channel requesters. Each winning sample is tagged with its channel number and written as one FIFO word. The block sits between the per-channel ADC capture logic and the FIFO write port. It also reports back-pressure via a saturating stall counter.

---
 rtl/analog_fifo_pkg.sv | 21 ++
 rtl/rr_arb_pick.sv | 28 ++
 rtl/adc_fifo_wr_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/analog_fifo_pkg.sv
// Shared definitions for the analog sample FIFO path: FIFO geometry,
// write-arbiter state encoding and the channel-tagged sample word format.
package analog_fifo_pkg;

    localparam int FIFO_DATA_W = 16;
    localparam int FIFO_DEPTH  = 15;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_WRITE = 1'b1
    } arb_state_e;

    // Word layout: channel id in the top two bits, zero-extended sample below.
    function automatic logic [FIFO_DATA_W-1:0] pack_sample(
        input logic [1:0]             ch_id,
        input logic [FIFO_DATA_W-3:0] smp
    );
        return {ch_id, smp};
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first eligible channel after i_last_gnt, wrapping.
// Purely combinational; no state, no backpressure.
module rr_arb_pick #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] i_elig,
    input  logic [1:0]      i_last_gnt,
    output logic            o_found,
    output logic [1:0]      o_id
);

    logic [N_CH-1:0] w_rot;

    // Bit j of w_rot is channel (last_gnt + 1 + j) mod N_CH.
    assign w_rot = N_CH'({i_elig, i_elig} >> (i_last_gnt + 3'd1));

    always_comb begin
        o_found = 1'b0;
        o_id    = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                o_found = 1'b1;
                o_id    = 2'((int'(i_last_gnt) + 1 + j) % N_CH);
            end
        end
    end

endmodule

// File: rtl/adc_fifo_wr_arbiter.sv
// Round-robin arbiter writing channel-tagged ADC samples into one shared FIFO.
// Latency: request seen in IDLE -> write/ack next cycle; at most one write per two cycles.
// Backpressure: fifo_full holds requests in IDLE and counts stall cycles.
module adc_fifo_wr_arbiter
    import analog_fifo_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SMP_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         i_ch_req,
    input  logic [N_CH*SMP_W-1:0]   i_ch_sample,
    input  logic [N_CH-1:0]         i_ch_mask,
    output logic [N_CH-1:0]         o_ch_ack,
    input  logic                    i_fifo_full,
    output logic                    o_fifo_wr_en,
    output logic [FIFO_DATA_W-1:0]  o_fifo_data,
    output logic [1:0]              o_gnt_id,
    output logic                    o_busy,
    input  logic                    i_stall_clr,
    output logic [15:0]             o_stall_cnt
);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [FIFO_DATA_W-1:0] r_fifo_data;
    logic [1:0]             r_gnt_id;
    logic [1:0]             r_last_gnt;
    logic [15:0]            r_stall_cnt;
    logic [N_CH-1:0]        r_ack;
    logic                   r_wr_en;
    logic                   r_busy;

    logic [N_CH-1:0]        w_elig;
    logic                   w_found;
    logic [1:0]             w_win_id;
    logic [SMP_W-1:0]       w_win_smp;
    logic [FIFO_DATA_W-3:0] w_smp_ext;
    logic [N_CH-1:0]        w_win_onehot;
    logic                   w_load;
    logic                   w_write;
    logic                   w_stall_inc;

    assign w_elig = i_ch_req & i_ch_mask;

    rr_arb_pick #(
        .N_CH (N_CH)
    ) u_pick (
        .i_elig     (w_elig),
        .i_last_gnt (r_last_gnt),
        .o_found    (w_found),
        .o_id       (w_win_id)
    );

    always_comb begin
        w_win_smp    = '0;
        w_win_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_win_id == 2'(i)) begin
                w_win_smp       = i_ch_sample[i*SMP_W +: SMP_W];
                w_win_onehot[i] = 1'b1;
            end
        end
        w_smp_ext              = '0;
        w_smp_ext[SMP_W-1:0]   = w_win_smp;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_write     = 1'b0;
        w_stall_inc = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    if (i_fifo_full) begin
                        w_stall_inc = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ARB_WRITE;
                    end
                end
            end
            ARB_WRITE: begin
                // WRITE always returns to IDLE so fifo_full is fresh at the next pick.
                w_write     = 1'b1;
                w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_data <= '0;
            r_gnt_id    <= '0;
            r_last_gnt  <= 2'(N_CH - 1);
            r_ack       <= '0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_en <= w_load;
            r_busy  <= w_load;
            r_ack   <= w_load ? w_win_onehot : '0;
            if (w_load) begin
                r_fifo_data <= pack_sample(w_win_id, w_smp_ext);
                r_gnt_id    <= w_win_id;
            end
            if (w_write) begin
                r_last_gnt <= r_gnt_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_ch_ack     = r_ack;
    assign o_fifo_wr_en = r_wr_en;
    assign o_fifo_data  = r_fifo_data;
    assign o_gnt_id     = r_gnt_id;
    assign o_busy       = r_busy;
    assign o_stall_cnt  = r_stall_cnt;

endmodule
